// File: rtl/shift_reg_siso_pkg.sv
// rtl/shift_reg_siso_pkg.sv - shared constants for the 4-stage serial shift register
package shift_reg_pkg;

  // Number of shift stages; the top exposes one discrete port per stage.
  localparam int SIPO_DEPTH = 4;

  // Width of the fill counter; must hold the value SIPO_DEPTH.
  localparam int FILL_W = 3;

  // Saturating increment used by the fill counter.
  function automatic logic [FILL_W-1:0] sat_inc(input logic [FILL_W-1:0] cnt);
    if (cnt >= FILL_W'(SIPO_DEPTH)) begin
      return FILL_W'(SIPO_DEPTH);
    end
    return cnt + FILL_W'(1);
  endfunction

endpackage

// File: rtl/shift_reg_siso_if.sv
// rtl/shift_reg_siso_if.sv - bundle of serial data and stage observation signals
interface shift_reg_siso_if;
  import shift_reg_pkg::*;

  logic              d;
  logic              q0;
  logic              q1;
  logic              q2;
  logic              q3;
  logic [3:0]        q_bus;
  logic [FILL_W-1:0] fill_cnt;
  logic              full;

  // Driver side: supplies serial data, observes the stages.
  modport master (
    output d,
    input  q0, q1, q2, q3, q_bus, fill_cnt, full
  );

  // Register side: consumes serial data, presents the stages.
  modport slave (
    input  d,
    output q0, q1, q2, q3, q_bus, fill_cnt, full
  );
endinterface

// File: rtl/shift_reg_siso_stage.sv
// rtl/shift_reg_siso_stage.sv - one shift stage, a D flop with async active-low clear
module siso_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic bit_d;
  logic bit_q;

  // Next value is simply the upstream bit; no enable on this chain.
  always_comb begin
    bit_d = d;
  end

  // Storage flop, cleared immediately while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= bit_d;
    end
  end

  assign q = bit_q;

endmodule

// File: rtl/shift_reg_siso.sv
// rtl/shift_reg_siso.sv - 4-stage serial-in serial-out shift register with fill tracking
module shift_reg_siso
  import shift_reg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              d,
  input  logic              rst,
  input  logic              clk,
  output logic              q0,
  output logic              q1,
  output logic              q2,
  output logic              q3,
  output logic [3:0]        q_bus,
  output logic [FILL_W-1:0] fill_cnt,
  output logic              full
);

  // Outputs q0..q3 are discrete ports, so any other depth cannot be honoured.
  if (DEPTH != SIPO_DEPTH) begin : g_bad_depth
    $error("shift_reg_siso: DEPTH must be 4");
  end

  logic [SIPO_DEPTH-1:0] stage_q;
  logic [FILL_W-1:0]     fill_cnt_d;
  logic [FILL_W-1:0]     fill_cnt_q;

  // Chain of stages: stage 0 takes d, each later stage takes its predecessor.
  for (genvar i = 0; i < SIPO_DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      siso_stage u_stage (
        .clk   (clk),
        .rst_n (rst),
        .d     (d),
        .q     (stage_q[i])
      );
    end else begin : g_tail
      siso_stage u_stage (
        .clk   (clk),
        .rst_n (rst),
        .d     (stage_q[i-1]),
        .q     (stage_q[i])
      );
    end
  end

  // Count edges since reset release, stopping once every stage holds fresh data.
  always_comb begin
    fill_cnt_d = sat_inc(fill_cnt_q);
  end

  // Fill counter register, cleared with the stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_cnt_q <= '0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
    end
  end

  assign q0       = stage_q[0];
  assign q1       = stage_q[1];
  assign q2       = stage_q[2];
  assign q3       = stage_q[3];
  assign q_bus    = {stage_q[0], stage_q[1], stage_q[2], stage_q[3]};
  assign fill_cnt = fill_cnt_q;
  assign full     = (fill_cnt_q == FILL_W'(SIPO_DEPTH));

endmodule

// File: tb/tb_shift_reg_siso.sv
// tb/tb_shift_reg_siso.sv - directed self-checking bench for shift_reg_siso
module tb_shift_reg_siso;
  import shift_reg_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  shift_reg_siso_if bus ();

  shift_reg_siso dut (
    .d        (bus.d),
    .rst      (rst),
    .clk      (clk),
    .q0       (bus.q0),
    .q1       (bus.q1),
    .q2       (bus.q2),
    .q3       (bus.q3),
    .q_bus    (bus.q_bus),
    .fill_cnt (bus.fill_cnt),
    .full     (bus.full)
  );

  // 10 time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge: drive d, pass one rising edge, return at the next falling edge.
  task automatic tick(input logic dv);
    bus.d = dv;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(i[0]);
      checks++;
      if (bus.q_bus !== 4'b0000) begin
        errors++;
        $display("FAIL reset_q_bus[%0d] got=%b exp=0000", i, bus.q_bus);
      end
      checks++;
      if (bus.fill_cnt !== 3'd0 || bus.full !== 1'b0) begin
        errors++;
        $display("FAIL reset_fill[%0d] got fill=%0d full=%b exp fill=0 full=0", i, bus.fill_cnt, bus.full);
      end
    end
  endtask

  task automatic test_pattern();
    logic       pat [4];
    logic [3:0] exp_bus [4];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    exp_bus = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(pat[i]);
      checks++;
      if (bus.q_bus !== exp_bus[i]) begin
        errors++;
        $display("FAIL pattern_q_bus[%0d] got=%b exp=%b", i, bus.q_bus, exp_bus[i]);
      end
      checks++;
      if (bus.fill_cnt !== 3'(i + 1) || bus.full !== (i == 3)) begin
        errors++;
        $display("FAIL pattern_fill[%0d] got fill=%0d full=%b exp fill=%0d full=%b",
                 i, bus.fill_cnt, bus.full, i + 1, (i == 3));
      end
    end
    checks++;
    if (bus.q3 !== 1'b1) begin
      errors++;
      $display("FAIL pattern_q3 got=%b exp=1", bus.q3);
    end
  endtask

  task automatic test_flush();
    logic [3:0] exp_bus [4];
    logic       exp_q3 [4];
    exp_bus = '{4'b0110, 4'b0011, 4'b0001, 4'b0000};
    exp_q3  = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      tick(1'b0);
      checks++;
      if (bus.q_bus !== exp_bus[i] || bus.q3 !== exp_q3[i]) begin
        errors++;
        $display("FAIL flush[%0d] got q_bus=%b q3=%b exp q_bus=%b q3=%b",
                 i, bus.q_bus, bus.q3, exp_bus[i], exp_q3[i]);
      end
      checks++;
      if (bus.fill_cnt !== 3'd4 || bus.full !== 1'b1) begin
        errors++;
        $display("FAIL flush_fill[%0d] got fill=%0d full=%b exp fill=4 full=1", i, bus.fill_cnt, bus.full);
      end
    end
  endtask

  task automatic test_latency();
    logic [3:0] exp_stages [5];
    logic [3:0] got;
    exp_stages = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      tick(i == 0);
      got = {bus.q0, bus.q1, bus.q2, bus.q3};
      checks++;
      if (got !== exp_stages[i]) begin
        errors++;
        $display("FAIL latency[%0d] got q0..q3=%b exp=%b", i, got, exp_stages[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) tick(1'b1);
    checks++;
    if (bus.q_bus !== 4'b1111) begin
      errors++;
      $display("FAIL midrst_load got=%b exp=1111", bus.q_bus);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.q_bus !== 4'b0000 || bus.fill_cnt !== 3'd0 || bus.full !== 1'b0 || bus.q3 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear got q_bus=%b fill=%0d full=%b exp q_bus=0000 fill=0 full=0",
               bus.q_bus, bus.fill_cnt, bus.full);
    end
    #1;
    rst = 1'b1;
    bus.d = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.q_bus !== 4'b1000 || bus.fill_cnt !== 3'd1) begin
      errors++;
      $display("FAIL midrst_release got q_bus=%b fill=%0d exp q_bus=1000 fill=1", bus.q_bus, bus.fill_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] model;
    logic       dv;
    int         exp_fill;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    model = 4'b0000;
    for (int i = 1; i <= 10; i++) begin
      dv = 1'($urandom_range(0, 1));
      tick(dv);
      model = {dv, model[3:1]};
      exp_fill = (i < 4) ? i : 4;
      checks++;
      if (bus.q_bus !== model) begin
        errors++;
        $display("FAIL sat_q_bus[%0d] got=%b exp=%b", i, bus.q_bus, model);
      end
      checks++;
      if (bus.fill_cnt !== 3'(exp_fill) || bus.full !== (exp_fill == 4)) begin
        errors++;
        $display("FAIL sat_fill[%0d] got fill=%0d full=%b exp fill=%0d full=%b",
                 i, bus.fill_cnt, bus.full, exp_fill, (exp_fill == 4));
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    bus.d  = 1'b0;
    @(negedge clk);
    test_reset();
    test_pattern();
    test_flush();
    test_latency();
    test_mid_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
